pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program sequencer that generates the program-memory address each cycle and replaces the plain free-running program counter. It sits directly upstream of the combinational program-memory/instruction-decoder stage. It drives that stage's `addr` input and takes back decoded flow-control strobes and the carry flag, supporting jumps, carry-conditional branches, call/return through a small hardware return stack, stall and halt.

## Interface
- `ADDR_W`, default 5: program-memory address width (32 words).
- `DEPTH`, default 4: return-stack entries (power of two, ≥2).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Stall`  in  1  hold the current address and stack; all other strobes are ignored.
- `Jump`  in  1  unconditional jump to `Target`.
- `JumpCY`  in  1  jump to `Target` only if `CY`=1.
- `CY`  in  1  carry flag from the CY register (registered value, current cycle).
- `Call`  in  1  push the return address and jump to `Target`.
- `Ret`  in  1  pop the return stack and jump to the popped address.
- `Halt`  in  1  enter HALT after this instruction.
- `Target`  in  ADDR_W  jump/call destination.
- `Addr`  out  ADDR_W  registered program-memory address.
- `Depth`  out  $clog2(DEPTH)+1  current number of stack entries.
- `Halted`  out  1  state == HALT.
- `Fault`  out  1  state == FAULT (stack overflow or underflow).

## Operation
- States:
  - RUN: normal sequencing.
  - HALT: `Addr` and stack frozen.
  - FAULT: `Addr` and stack frozen.
  - HALT and FAULT are exited only by `Reset`.
- In RUN, the next address is chosen by priority, highest first:
  - `Stall`: hold `Addr` and stack.
  - `Ret`:
    - `Depth`==0: go to FAULT; `Addr` holds.
    - Otherwise: `Addr` ← top of stack; `Depth` −1.
  - `Call`:
    - `Depth`==DEPTH: go to FAULT; `Addr` holds.
    - Otherwise: push `Addr`+1 (mod 2^ADDR_W); `Addr` ← `Target`; `Depth` +1.
  - `Jump`, or `JumpCY` with `CY`=1: `Addr` ← `Target`.
  - Otherwise: `Addr` ← `Addr`+1, wrapping 2^ADDR_W−1 → 0.
- `Halt` (not stalled) and RUN: go to HALT. `Addr` still takes the next address per the priority above, so the instruction at `Addr` completes its flow effect once.
- When several strobes are asserted together, only the highest-priority one takes effect. Lower-priority strobes have no side effect; for example, `Ret`+`Call` pops only.
- `JumpCY` with `CY`=0 falls through to increment.
- Address arithmetic is unsigned ADDR_W-bit modulo; no carry out.
- The stack is LIFO with a pointer equal to `Depth`. Entries above the pointer are don't-care.

## Timing
- All control inputs are sampled at the rising edge of `clk`. `Addr` reflects the decision after that edge, so there is 1-cycle latency from strobe to new address.
- There is no combinational path from any input to any output.
- Reset values: `Addr`=0, `Depth`=0, `Halted`=0, `Fault`=0, state RUN. Stack contents are not reset.
- `Reset` asserted in any state, including mid-call or FAULT, takes effect immediately and asynchronously. The first increment occurs on the first rising edge after `Reset` deasserts.
- Stall has zero-cycle overhead: deasserting `Stall` resumes at the held `Addr` on the next edge.

## Structure
- Shared package `pc_seq_pkg`: `pc_state_t` enum {RUN, HALT, FAULT} and default constants `PC_ADDR_W`=5 and `PC_STACK_DEPTH`=4.
- One sub-module, `pc_return_stack`, contains:
  - the register array, pointer and full/empty flags;
  - push/pop ports, with push and pop mutually exclusive by construction;
  - a `top` output.
- The top level holds the state FSM, the next-address mux and the `Addr` register.

## Test plan
- Reset held for 6 ns, then released, with no strobes → `Addr` sequence 0,1,…,31,0,1 (wrap), with `Depth`=0 throughout.
- At `Addr`=3, `Jump`=1 with `Target`=20 → next `Addr`=20, then 21.
- Carry-conditional branch, `Target`=12:
  - At `Addr`=7, `JumpCY`=1 with `CY`=0 → `Addr`=8.
  - At `Addr`=9, `JumpCY`=1 with `CY`=1 → `Addr`=12.
- Call/return:
  - At `Addr`=2, `Call` with `Target`=10 → `Addr`=10, `Depth`=1.
  - At `Addr`=10, `Call` with `Target`=31 → `Addr`=31, `Depth`=2.
  - Next cycle, `Ret` → `Addr`=11, `Depth`=1.
  - Next `Ret` → `Addr`=3, `Depth`=0.
- Fault cases:
  - Five nested `Call`s with DEPTH=4 → fifth gives `Fault`=1 with `Addr` frozen at the call site and `Depth`=4.
  - Separately, `Ret` with `Depth`=0 → `Fault`=1.
  - In both cases `Reset` then clears to `Addr`=0, `Fault`=0.
- Stall, halt and mid-operation reset:
  - `Stall` for 3 cycles at `Addr`=5 with `Jump` also asserted → `Addr` stays 5. After release, increments to 6.
  - `Halt` at `Addr`=6 → `Addr`=7, `Halted`=1, frozen for 10 cycles.
  - Async `Reset` pulse between clock edges → `Addr`=0 immediately.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program sequencer.
// Sequencer states and address/stack sizing defaults.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        RUN,
        HALT,
        FAULT
    } pc_state_t;

    localparam int PC_ADDR_W      = 5;
    localparam int PC_STACK_DEPTH = 4;

endpackage

// File: rtl/pc_return_stack.sv
// Hardware return-address stack for call/return.
// Pop wins over push; overflow/underflow requests are dropped.
module pc_return_stack
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = PC_ADDR_W,
    parameter int DEPTH  = PC_STACK_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [ADDR_W-1:0]      data_i,
    output logic [ADDR_W-1:0]      top_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int IW = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [IW:0]       ptr_q;
    logic [IW:0]       ptr_d;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     top_idx;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (ptr_q == (IW+1)'(DEPTH));
    assign empty_o = (ptr_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && !pop_i && !full_o;
    assign wr_idx  = ptr_q[IW-1:0];
    assign top_idx = ptr_q[IW-1:0] - IW'(1);
    assign top_o   = mem_q[top_idx];
    assign count_o = ptr_q;

    // Next pointer: pop decrements, push increments.
    always_comb begin
        ptr_d = ptr_q;
        if (do_pop) begin
            ptr_d = ptr_q - (IW+1)'(1);
        end else if (do_push) begin
            ptr_d = ptr_q + (IW+1)'(1);
        end
    end

    // Pointer register, cleared by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Entry storage; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: next-address mux, state FSM and Addr register.
// Feeds the program-memory stage and reacts to its flow strobes.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = PC_ADDR_W,
    parameter int DEPTH  = PC_STACK_DEPTH
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   Stall,
    input  logic                   Jump,
    input  logic                   JumpCY,
    input  logic                   CY,
    input  logic                   Call,
    input  logic                   Ret,
    input  logic                   Halt,
    input  logic [ADDR_W-1:0]      Target,
    output logic [ADDR_W-1:0]      Addr,
    output logic [$clog2(DEPTH):0] Depth,
    output logic                   Halted,
    output logic                   Fault
);

    pc_state_t         state_q;
    pc_state_t         state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_full;
    logic              stk_empty;

    assign ret_addr = addr_q + ADDR_W'(1);

    pc_return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_stack (
        .clk_i   (clk),
        .rst_i   (Reset),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .data_i  (ret_addr),
        .top_o   (stk_top),
        .count_o (Depth),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    // Priority next-address selection and state transitions.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (state_q == RUN && !Stall) begin
            if (Ret) begin
                if (stk_empty) begin
                    state_d = FAULT;
                end else begin
                    stk_pop = 1'b1;
                    addr_d  = stk_top;
                end
            end else if (Call) begin
                if (stk_full) begin
                    state_d = FAULT;
                end else begin
                    stk_push = 1'b1;
                    addr_d   = Target;
                end
            end else if (Jump || (JumpCY && CY)) begin
                addr_d = Target;
            end else begin
                addr_d = ret_addr;
            end
            if (Halt && state_d == RUN) begin
                state_d = HALT;
            end
        end
    end

    // State and address registers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= RUN;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign Addr   = addr_q;
    assign Halted = (state_q == HALT);
    assign Fault  = (state_q == FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer with a queue-based reference model.
// Directed scenarios pin the model; random strobes exercise the rest.
module tb_pc_sequencer;

    logic       clk    = 1'b0;
    logic       Reset  = 1'b1;
    logic       Stall  = 1'b0;
    logic       Jump   = 1'b0;
    logic       JumpCY = 1'b0;
    logic       CY     = 1'b0;
    logic       Call   = 1'b0;
    logic       Ret    = 1'b0;
    logic       Halt   = 1'b0;
    logic [4:0] Target = '0;
    logic [4:0] Addr;
    logic [2:0] Depth;
    logic       Halted;
    logic       Fault;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: 0=run 1=halt 2=fault
    int m_addr  = 0;
    int m_state = 0;
    int m_stk[$];

    pc_sequencer #(.ADDR_W(5), .DEPTH(4)) dut (
        .clk    (clk),
        .Reset  (Reset),
        .Stall  (Stall),
        .Jump   (Jump),
        .JumpCY (JumpCY),
        .CY     (CY),
        .Call   (Call),
        .Ret    (Ret),
        .Halt   (Halt),
        .Target (Target),
        .Addr   (Addr),
        .Depth  (Depth),
        .Halted (Halted),
        .Fault  (Fault)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Model update from the sequencing rules.
    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            m_addr  = 0;
            m_state = 0;
            m_stk.delete();
        end else if (m_state == 0 && !Stall) begin
            bit f;
            int nxt;
            f = 0;
            nxt = m_addr;
            if (Ret) begin
                if (m_stk.size() == 0) f = 1;
                else nxt = m_stk.pop_back();
            end else if (Call) begin
                if (m_stk.size() == 4) f = 1;
                else begin
                    m_stk.push_back((m_addr + 1) % 32);
                    nxt = int'(Target);
                end
            end else if (Jump || (JumpCY && CY)) begin
                nxt = int'(Target);
            end else begin
                nxt = (m_addr + 1) % 32;
            end
            if (f) m_state = 2;
            else begin
                m_addr = nxt;
                if (Halt) m_state = 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!Reset) begin
            vectors++;
            if (Addr !== 5'(m_addr) || Depth !== 3'(m_stk.size()) ||
                Halted !== (m_state == 1) || Fault !== (m_state == 2)) begin
                miscompares++;
                $display("FAIL model: Addr=%0d Depth=%0d H=%0b F=%0b want %0d %0d %0b %0b",
                         Addr, Depth, Halted, Fault, m_addr, m_stk.size(),
                         m_state == 1, m_state == 2);
            end
        end
    end

    task automatic adv(int a);
        int n = 0;
        while (m_addr != a && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (m_addr != a) begin
            miscompares++;
            $display("FAIL adv_timeout: got %0d, want %0d", m_addr, a);
        end
    endtask

    task automatic reset_pulse(string name);
        Reset = 1'b1;
        #1;
        check({name, "_addr"}, int'(Addr), 0);
        check({name, "_fault"}, int'(Fault), 0);
        check({name, "_depth"}, int'(Depth), 0);
        @(negedge clk);
        Reset = 1'b0;
    endtask

    initial begin
        #6 Reset = 1'b0;
        @(negedge clk);
        check("rst_addr", int'(Addr), 0);
        check("rst_depth", int'(Depth), 0);
        check("rst_halted", int'(Halted), 0);
        check("rst_fault", int'(Fault), 0);
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            check("wrap_addr", int'(Addr), i % 32);
            check("wrap_depth", int'(Depth), 0);
        end

        adv(3);
        Jump = 1'b1; Target = 5'd20;
        @(negedge clk);
        Jump = 1'b0;
        check("jump", int'(Addr), 20);
        @(negedge clk);
        check("jump_inc", int'(Addr), 21);

        adv(7);
        JumpCY = 1'b1; CY = 1'b0; Target = 5'd12;
        @(negedge clk);
        JumpCY = 1'b0;
        check("jcy0", int'(Addr), 8);
        @(negedge clk);
        JumpCY = 1'b1; CY = 1'b1;
        @(negedge clk);
        JumpCY = 1'b0; CY = 1'b0;
        check("jcy1", int'(Addr), 12);

        adv(2);
        Call = 1'b1; Target = 5'd10;
        @(negedge clk);
        check("call1_addr", int'(Addr), 10);
        check("call1_depth", int'(Depth), 1);
        Target = 5'd31;
        @(negedge clk);
        Call = 1'b0;
        check("call2_addr", int'(Addr), 31);
        check("call2_depth", int'(Depth), 2);
        Ret = 1'b1;
        @(negedge clk);
        check("ret1_addr", int'(Addr), 11);
        check("ret1_depth", int'(Depth), 1);
        @(negedge clk);
        Ret = 1'b0;
        check("ret2_addr", int'(Addr), 3);
        check("ret2_depth", int'(Depth), 0);

        Call = 1'b1; Target = 5'd16;
        repeat (4) @(negedge clk);
        check("ovf_pre_depth", int'(Depth), 4);
        check("ovf_pre_fault", int'(Fault), 0);
        @(negedge clk);
        Call = 1'b0;
        check("ovf_fault", int'(Fault), 1);
        check("ovf_addr", int'(Addr), 16);
        check("ovf_depth", int'(Depth), 4);
        repeat (3) @(negedge clk);
        check("ovf_frozen", int'(Addr), 16);
        reset_pulse("ovf_rst");

        Ret = 1'b1;
        @(negedge clk);
        Ret = 1'b0;
        check("udf_fault", int'(Fault), 1);
        check("udf_addr", int'(Addr), 0);
        reset_pulse("udf_rst");

        adv(5);
        Stall = 1'b1; Jump = 1'b1; Target = 5'd25;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hold", int'(Addr), 5);
        end
        Stall = 1'b0; Jump = 1'b0;
        @(negedge clk);
        check("stall_resume", int'(Addr), 6);
        Halt = 1'b1;
        @(negedge clk);
        Halt = 1'b0;
        check("halt_addr", int'(Addr), 7);
        check("halt_flag", int'(Halted), 1);
        repeat (10) @(negedge clk);
        check("halt_frozen", int'(Addr), 7);
        check("halt_still", int'(Halted), 1);

        #2 Reset = 1'b1;
        #1;
        check("async_addr", int'(Addr), 0);
        check("async_halted", int'(Halted), 0);
        #1 Reset = 1'b0;

        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            Reset  = (m_state != 0) && ($urandom_range(0, 2) == 0);
            Stall  = ($urandom_range(0, 9) == 0);
            Ret    = ($urandom_range(0, 7) == 0);
            Call   = ($urandom_range(0, 5) == 0);
            Jump   = ($urandom_range(0, 7) == 0);
            JumpCY = ($urandom_range(0, 4) == 0);
            CY     = 1'($urandom);
            Halt   = ($urandom_range(0, 39) == 0);
            Target = 5'($urandom);
        end
        @(negedge clk);
        Reset = 1'b0; Stall = 1'b0; Ret = 1'b0; Call = 1'b0;
        Jump = 1'b0; JumpCY = 1'b0; Halt = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
